// File: rtl/lc3_dp_pkg.sv
// lc3_dp_pkg
// Purpose: shared types and helpers for the LC-3 datapath and its memory interface.
//   aluk_t / pcmux_t / addr2mux_t : control-field encodings
//   mem_state_t                   : memory handshake FSM states
//   sext(value, from_width)       : sign-extend the low from_width bits of value
// Ports: none (package).
package lc3_dp_pkg;

  // sext() returns SEXT_W bits; callers size-cast down to their WIDTH,
  // so WIDTH up to 64 is supported.
  localparam int SEXT_W = 64;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_PASS = 2'b11
  } aluk_t;

  typedef enum logic [1:0] {
    PC_INC   = 2'b00,
    PC_BUS   = 2'b01,
    PC_ADDER = 2'b10,
    PC_HOLD  = 2'b11
  } pcmux_t;

  typedef enum logic [1:0] {
    A2_ZERO  = 2'b00,
    A2_OFF6  = 2'b01,
    A2_OFF9  = 2'b10,
    A2_OFF11 = 2'b11
  } addr2mux_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mem_state_t;

  // Move bit (from_width-1) up to the MSB, then arithmetic-shift back down.
  // Bits above from_width are discarded by the first shift, so the whole
  // 16-bit IR can be passed in directly.
  function automatic logic [SEXT_W-1:0] sext(input logic [15:0] value, input int from_width);
    logic signed [SEXT_W-1:0] t;
    t = {value, {(SEXT_W-16){1'b0}}};
    t = t << (16 - from_width);
    t = t >>> (SEXT_W - from_width);
    return t;
  endfunction

endpackage

// File: rtl/lc3_mem_if.sv
// lc3_mem_if
// Purpose: valid/ready memory handshake with a BUSY-cycle timeout. Latches the
//   request (address, write data, direction) on start so the datapath may keep
//   changing MAR/MDR while an access is in flight.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start, i_we       start request (IDLE only) and its direction
//   i_mar, i_mdr        request address / write data, sampled on start
//   i_rdata, i_ready    memory response
//   o_valid, o_write, o_addr, o_wdata   request toward memory
//   o_done              one-cycle end-of-access pulse
//   o_err               sticky timeout flag
//   o_idle              FSM is IDLE (datapath may load MDR from the bus)
//   o_mdr_ld, o_mdr_val read data to be written into MDR this edge
module lc3_mem_if
  import lc3_dp_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_mar,
  input  logic [WIDTH-1:0] i_mdr,
  input  logic [WIDTH-1:0] i_rdata,
  input  logic             i_ready,
  output logic             o_valid,
  output logic             o_write,
  output logic [WIDTH-1:0] o_addr,
  output logic [WIDTH-1:0] o_wdata,
  output logic             o_done,
  output logic             o_err,
  output logic             o_idle,
  output logic             o_mdr_ld,
  output logic [WIDTH-1:0] o_mdr_val
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  mem_state_t       r_state, w_state_next;
  logic [CW-1:0]    r_cnt;
  logic             r_write, r_err;
  logic [WIDTH-1:0] r_addr, r_wdata;
  logic             w_timeout;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Ready is checked before the timeout so a coincident ready completes normally.
  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_state_next = BUSY;
      BUSY: begin
        if (i_ready) begin
          w_state_next = DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = DONE;
          w_timeout    = 1'b1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_write <= i_we;
        r_addr  <= i_mar;
        r_wdata <= i_mdr;
        r_cnt   <= '0;
      end else if (r_state == BUSY && !i_ready && !w_timeout) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign o_valid   = (r_state == BUSY);
  assign o_done    = (r_state == DONE);
  assign o_idle    = (r_state == IDLE);
  assign o_write   = r_write;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;
  assign o_err     = r_err;
  assign o_mdr_ld  = (r_state == BUSY) && i_ready && !r_write;
  assign o_mdr_val = i_rdata;

endmodule

// File: rtl/lc3_datapath_p.sv
// lc3_datapath_p
// Purpose: parametrised LC-3 datapath (PC, MAR, MDR, IR, R0..R7, ALU, address
//   adder, NZP, BEN) around a gated internal bus, with memory reached through
//   lc3_mem_if. Sole owner of architectural state; driven by the ISDU.
// Ports:
//   Clk, Reset                         clock, asynchronous active-high reset
//   LD_MAR..LD_PC                      register load enables
//   GatePC/GateMDR/GateALU/GateMARMUX  bus drivers (one-hot or none)
//   PCMUX, ADDR1MUX, ADDR2MUX, MARMUX, SR1MUX, DRMUX, SR2MUX, ALUK  mux selects
//   mem_start, mem_we, mem_rdata, mem_ready  memory request / response in
//   mem_valid, mem_write, mem_addr, mem_wdata, mem_done, mem_err  memory out
//   bus_err                            sticky multi-gate flag
//   PC, MAR, MDR, IR, BEN, NZP         architectural state
module lc3_datapath_p
  import lc3_dp_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] PC_RST      = '0,
  parameter int               MEM_TIMEOUT = 255
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_MAR,
  input  logic             LD_MDR,
  input  logic             LD_IR,
  input  logic             LD_BEN,
  input  logic             LD_CC,
  input  logic             LD_REG,
  input  logic             LD_PC,
  input  logic             GatePC,
  input  logic             GateMDR,
  input  logic             GateALU,
  input  logic             GateMARMUX,
  input  logic [1:0]       PCMUX,
  input  logic             ADDR1MUX,
  input  logic [1:0]       ADDR2MUX,
  input  logic             MARMUX,
  input  logic             SR1MUX,
  input  logic             DRMUX,
  input  logic             SR2MUX,
  input  logic [1:0]       ALUK,
  input  logic             mem_start,
  input  logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             mem_valid,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_done,
  output logic             mem_err,
  output logic             bus_err,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] MAR,
  output logic [WIDTH-1:0] MDR,
  output logic [WIDTH-1:0] IR,
  output logic             BEN,
  output logic [2:0]       NZP
);

  logic [WIDTH-1:0] r_pc, r_mar, r_mdr, r_ir;
  logic [WIDTH-1:0] r_regs [8];
  logic             r_ben, r_bus_err;
  logic [2:0]       r_nzp;

  logic [WIDTH-1:0] w_bus, w_sr1, w_sr2, w_alu, w_addr1, w_addr2, w_adder;
  logic [WIDTH-1:0] w_marmux, w_pc_next, w_mdr_val;
  logic [2:0]       w_sr1_idx, w_dr_idx, w_nzp_bus;
  logic [3:0]       w_gates;
  logic             w_multi, w_mdr_ld, w_mem_idle, w_ben_next;

  // Bus: more than one gate forces 0 instead of a wired-OR of the drivers.
  assign w_gates = {GatePC, GateMDR, GateALU, GateMARMUX};
  assign w_multi = |(w_gates & (w_gates - 4'd1));

  always_comb begin
    w_bus = '0;
    if (!w_multi) begin
      w_bus = ({WIDTH{GatePC}}     & r_pc)  |
              ({WIDTH{GateMDR}}    & r_mdr) |
              ({WIDTH{GateALU}}    & w_alu) |
              ({WIDTH{GateMARMUX}} & w_marmux);
    end
  end

  // Register file operands
  assign w_sr1_idx = SR1MUX ? r_ir[8:6] : r_ir[11:9];
  assign w_dr_idx  = DRMUX  ? 3'd7      : r_ir[11:9];
  assign w_sr1     = r_regs[w_sr1_idx];
  assign w_sr2     = SR2MUX ? WIDTH'(sext(r_ir[15:0], 5)) : r_regs[r_ir[2:0]];

  always_comb begin
    case (aluk_t'(ALUK))
      ALU_ADD:  w_alu = w_sr1 + w_sr2;
      ALU_AND:  w_alu = w_sr1 & w_sr2;
      ALU_NOT:  w_alu = ~w_sr1;
      default:  w_alu = w_sr1;
    endcase
  end

  // Address adder
  assign w_addr1 = ADDR1MUX ? w_sr1 : r_pc;

  always_comb begin
    case (addr2mux_t'(ADDR2MUX))
      A2_ZERO:  w_addr2 = '0;
      A2_OFF6:  w_addr2 = WIDTH'(sext(r_ir[15:0], 6));
      A2_OFF9:  w_addr2 = WIDTH'(sext(r_ir[15:0], 9));
      default:  w_addr2 = WIDTH'(sext(r_ir[15:0], 11));
    endcase
  end

  assign w_adder  = w_addr1 + w_addr2;
  assign w_marmux = MARMUX ? w_adder : {{(WIDTH-8){1'b0}}, r_ir[7:0]};

  always_comb begin
    case (pcmux_t'(PCMUX))
      PC_INC:   w_pc_next = r_pc + 1'b1;
      PC_BUS:   w_pc_next = w_bus;
      PC_ADDER: w_pc_next = w_adder;
      default:  w_pc_next = r_pc;
    endcase
  end

  // Condition codes from the bus; BEN always sees the pre-update NZP.
  assign w_nzp_bus  = w_bus[WIDTH-1] ? 3'b100 : ((w_bus == '0) ? 3'b010 : 3'b001);
  assign w_ben_next = (r_ir[11] & r_nzp[2]) | (r_ir[10] & r_nzp[1]) | (r_ir[9] & r_nzp[0]);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc      <= PC_RST;
      r_mar     <= '0;
      r_mdr     <= '0;
      r_ir      <= '0;
      r_ben     <= 1'b0;
      r_nzp     <= 3'b010;
      r_bus_err <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      if (LD_PC)  r_pc  <= w_pc_next;
      if (LD_MAR) r_mar <= w_bus;
      if (LD_IR)  r_ir  <= w_bus;
      // Memory read data has priority; bus loads only while no access is active.
      if (w_mdr_ld)                  r_mdr <= w_mdr_val;
      else if (LD_MDR && w_mem_idle) r_mdr <= w_bus;
      if (LD_CC)   r_nzp <= w_nzp_bus;
      if (LD_BEN)  r_ben <= w_ben_next;
      if (LD_REG)  r_regs[w_dr_idx] <= w_bus;
      if (w_multi) r_bus_err <= 1'b1;
    end
  end

  lc3_mem_if #(
    .WIDTH       (WIDTH),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_if (
    .i_clk     (Clk),
    .i_rst     (Reset),
    .i_start   (mem_start),
    .i_we      (mem_we),
    .i_mar     (r_mar),
    .i_mdr     (r_mdr),
    .i_rdata   (mem_rdata),
    .i_ready   (mem_ready),
    .o_valid   (mem_valid),
    .o_write   (mem_write),
    .o_addr    (mem_addr),
    .o_wdata   (mem_wdata),
    .o_done    (mem_done),
    .o_err     (mem_err),
    .o_idle    (w_mem_idle),
    .o_mdr_ld  (w_mdr_ld),
    .o_mdr_val (w_mdr_val)
  );

  assign PC      = r_pc;
  assign MAR     = r_mar;
  assign MDR     = r_mdr;
  assign IR      = r_ir;
  assign BEN     = r_ben;
  assign NZP     = r_nzp;
  assign bus_err = r_bus_err;

endmodule

// File: tb/tb_lc3_datapath_p.sv
// tb_lc3_datapath_p
// Purpose: directed, self-checking bench for lc3_datapath_p. Expected values
//   are queued when stimulus is applied and popped when the DUT output is read.
// Ports: none (top-level bench).
module tb_lc3_datapath_p;

  localparam int          W    = 16;
  localparam logic [15:0] PCR  = 16'h3000;
  localparam int          TOUT = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic ADDR1MUX, MARMUX, SR1MUX, DRMUX, SR2MUX;
  logic mem_start, mem_we, mem_ready;
  logic [W-1:0] mem_rdata;
  logic mem_valid, mem_write, mem_done, mem_err, bus_err, BEN;
  logic [W-1:0] mem_addr, mem_wdata, PC, MAR, MDR, IR;
  logic [2:0] NZP;

  always #5 Clk = ~Clk;

  lc3_datapath_p #(.WIDTH(W), .PC_RST(PCR), .MEM_TIMEOUT(TOUT)) dut (
    .Clk(Clk), .Reset(Reset),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .MARMUX(MARMUX),
    .SR1MUX(SR1MUX), .DRMUX(DRMUX), .SR2MUX(SR2MUX), .ALUK(ALUK),
    .mem_start(mem_start), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_err(mem_err),
    .bus_err(bus_err), .PC(PC), .MAR(MAR), .MDR(MDR), .IR(IR), .BEN(BEN), .NZP(NZP)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic expect_val(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic observe(input logic [31:0] obs);
    sb_item_t it;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=0x%0h expected=<queued value>", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", it.tag, obs, it.exp);
      end
      $display("txn %s observed=0x%0h expected=0x%0h", it.tag, obs, it.exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_ctl();
    LD_MAR = 0; LD_MDR = 0; LD_IR = 0; LD_BEN = 0; LD_CC = 0; LD_REG = 0; LD_PC = 0;
    GatePC = 0; GateMDR = 0; GateALU = 0; GateMARMUX = 0;
    PCMUX = 2'b11; ADDR1MUX = 0; ADDR2MUX = 0; MARMUX = 0;
    SR1MUX = 0; DRMUX = 0; SR2MUX = 0; ALUK = 0;
    mem_start = 0; mem_we = 0;
  endtask

  // Read access answered on the first BUSY cycle; leaves the FSM IDLE.
  task automatic load_mdr(input logic [15:0] v);
    mem_start = 1; mem_we = 0;
    tick();
    mem_start = 0; mem_ready = 1; mem_rdata = v;
    tick();
    mem_ready = 0;
    tick();
  endtask

  task automatic set_ir(input logic [15:0] v);
    load_mdr(v);
    GateMDR = 1; LD_IR = 1;
    tick();
    idle_ctl();
  endtask

  task automatic write_reg(input logic [2:0] n, input logic [15:0] v);
    set_ir({4'b0, n, 9'b0});
    load_mdr(v);
    GateMDR = 1; LD_REG = 1; DRMUX = 0;
    tick();
    idle_ctl();
  endtask

  // Copies R[n] into MAR through the ALU pass path.
  task automatic read_reg(input logic [2:0] n);
    set_ir({4'b0, n, 9'b0});
    SR1MUX = 0; ALUK = 2'b11; GateALU = 1; LD_MAR = 1;
    tick();
    idle_ctl();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    idle_ctl();
    mem_ready = 0; mem_rdata = '0;
    Reset = 1;
    repeat (2) @(posedge Clk);
    #1 Reset = 0;

    // T1: reset state
    expect_val("rst_pc", 32'(PCR));
    expect_val("rst_nzp", 32'h2);
    expect_val("rst_mar", 0);
    expect_val("rst_mdr", 0);
    expect_val("rst_ir", 0);
    expect_val("rst_ben", 0);
    expect_val("rst_valid", 0);
    expect_val("rst_done", 0);
    expect_val("rst_mem_err", 0);
    expect_val("rst_bus_err", 0);
    expect_val("rst_addr", 0);
    observe(32'(PC)); observe(32'(NZP)); observe(32'(MAR)); observe(32'(MDR));
    observe(32'(IR)); observe(32'(BEN)); observe(32'(mem_valid)); observe(32'(mem_done));
    observe(32'(mem_err)); observe(32'(bus_err)); observe(32'(mem_addr));
    for (int r = 0; r < 8; r++) begin
      expect_val($sformatf("rst_R%0d", r), 0);
      read_reg(3'(r));
      observe(32'(MAR));
    end

    expect_val("T1_pc_inc3", 32'(PCR) + 3);
    PCMUX = 2'b00; LD_PC = 1;
    repeat (3) tick();
    idle_ctl();
    observe(32'(PC));

    // T2: ADD R3,R1,R2 and branch enable
    write_reg(3'd1, 16'h0005);
    write_reg(3'd2, 16'hFFFD);
    set_ir(16'h1642);
    expect_val("T2_nzp", 32'h1);
    expect_val("T2_r3", 32'h2);
    SR1MUX = 1; SR2MUX = 0; ALUK = 2'b00; GateALU = 1; LD_REG = 1; LD_CC = 1; DRMUX = 0;
    tick();
    idle_ctl();
    observe(32'(NZP));
    read_reg(3'd3);
    observe(32'(MAR));

    set_ir(16'h0401);
    expect_val("T2_ben_brz", 0);
    LD_BEN = 1; tick(); idle_ctl();
    observe(32'(BEN));

    // BEN uses old NZP (P) while LD_CC of a zero bus updates NZP in the same edge
    set_ir(16'h0201);
    expect_val("ben_old_nzp", 1);
    expect_val("nzp_zero_bus", 32'h2);
    LD_BEN = 1; LD_CC = 1; tick(); idle_ctl();
    observe(32'(BEN)); observe(32'(NZP));

    set_ir(16'h0801);
    expect_val("ben_brn", 0);
    LD_BEN = 1; tick(); idle_ctl();
    observe(32'(BEN));

    // ALU NOT, ADD immediate, AND register
    set_ir(16'h0040);
    expect_val("not_r1", 32'hFFFA);
    expect_val("nzp_neg", 32'h4);
    SR1MUX = 1; ALUK = 2'b10; GateALU = 1; LD_MAR = 1; LD_CC = 1; tick(); idle_ctl();
    observe(32'(MAR)); observe(32'(NZP));

    set_ir(16'h10BF);
    expect_val("add_imm_neg", 32'hFFFC);
    SR1MUX = 1; SR2MUX = 1; ALUK = 2'b00; GateALU = 1; LD_MAR = 1; tick(); idle_ctl();
    observe(32'(MAR));

    set_ir(16'h5081);
    expect_val("and_reg", 32'h0005);
    SR1MUX = 1; SR2MUX = 0; ALUK = 2'b01; GateALU = 1; LD_MAR = 1; tick(); idle_ctl();
    observe(32'(MAR));

    // Address adder, MARMUX and PCMUX
    set_ir(16'h05FE);
    expect_val("pc_off9_neg", 32'(PCR) + 1);
    expect_val("marmux_zext", 32'h00FE);
    ADDR1MUX = 0; ADDR2MUX = 2'b10; PCMUX = 2'b10; LD_PC = 1;
    GateMARMUX = 1; MARMUX = 0; LD_MAR = 1;
    tick(); idle_ctl();
    observe(32'(PC)); observe(32'(MAR));

    set_ir(16'h007F);
    expect_val("mar_sr1_off6", 32'h4);
    expect_val("pc_from_bus", 32'h4);
    SR1MUX = 1; ADDR1MUX = 1; ADDR2MUX = 2'b01; MARMUX = 1; GateMARMUX = 1;
    LD_MAR = 1; PCMUX = 2'b01; LD_PC = 1;
    tick(); idle_ctl();
    observe(32'(MAR)); observe(32'(PC));

    set_ir(16'h07FF);
    expect_val("pc_off11_neg", 32'h3);
    ADDR1MUX = 0; ADDR2MUX = 2'b11; PCMUX = 2'b10; LD_PC = 1; tick(); idle_ctl();
    observe(32'(PC));
    expect_val("pc_hold", 32'h3);
    PCMUX = 2'b11; LD_PC = 1; tick(); idle_ctl();
    observe(32'(PC));

    // T3: read at 0x3000, ready on the third BUSY edge, disturbance mid-flight
    load_mdr(16'h3000);
    expect_val("T3_mar", 32'h3000);
    GateMDR = 1; LD_MAR = 1; tick(); idle_ctl();
    observe(32'(MAR));
    load_mdr(16'h1111);
    pulses = 0;
    expect_val("T3_valid", 1);
    expect_val("T3_addr0", 32'h3000);
    mem_start = 1; mem_we = 0; tick(); mem_start = 0;
    pulses += int'(mem_done);
    observe(32'(mem_valid)); observe(32'(mem_addr));
    expect_val("T3_addr1", 32'h3000);
    expect_val("T3_mdr_ignored", 32'h1111);
    expect_val("T3_write_kept", 0);
    GatePC = 1; LD_MAR = 1; LD_MDR = 1; mem_start = 1; mem_we = 1;
    tick(); idle_ctl();
    pulses += int'(mem_done);
    observe(32'(mem_addr)); observe(32'(MDR)); observe(32'(mem_write));
    tick();
    pulses += int'(mem_done);
    expect_val("T3_mdr_rdata", 32'hBEEF);
    expect_val("T3_done", 1);
    expect_val("T3_valid_low", 0);
    expect_val("T3_addr2", 32'h3000);
    expect_val("T3_err", 0);
    mem_ready = 1; mem_rdata = 16'hBEEF; tick(); mem_ready = 0;
    pulses += int'(mem_done);
    observe(32'(MDR)); observe(32'(mem_done)); observe(32'(mem_valid));
    observe(32'(mem_addr)); observe(32'(mem_err));
    tick();
    pulses += int'(mem_done);
    expect_val("T3_done_pulses", 1);
    observe(32'(pulses));

    // Ready coinciding with the timeout edge: completes without error
    expect_val("coinc_done", 1);
    expect_val("coinc_err", 0);
    expect_val("coinc_mdr", 32'hA5A5);
    mem_start = 1; mem_we = 0; tick(); mem_start = 0;
    repeat (3) tick();
    mem_ready = 1; mem_rdata = 16'hA5A5; tick(); mem_ready = 0;
    observe(32'(mem_done)); observe(32'(mem_err)); observe(32'(MDR));
    tick();

    // Write access latches MAR/MDR and does not load MDR
    expect_val("wr_write", 1);
    expect_val("wr_wdata", 32'hA5A5);
    expect_val("wr_addr", 32'h3);
    mem_start = 1; mem_we = 1; tick(); idle_ctl();
    observe(32'(mem_write)); observe(32'(mem_wdata)); observe(32'(mem_addr));
    expect_val("wr_mdr_kept", 32'hA5A5);
    mem_ready = 1; mem_rdata = 16'h7777; tick(); mem_ready = 0;
    observe(32'(MDR));
    tick();

    // T4: timeout with ready held low
    expect_val("T4_done_cycles", 5);
    expect_val("T4_err", 1);
    expect_val("T4_mdr", 32'hA5A5);
    mem_start = 1; mem_we = 0; tick(); mem_start = 0;
    n = 1;
    while (!mem_done && n < 20) begin
      tick();
      n++;
    end
    observe(32'(n)); observe(32'(mem_err)); observe(32'(MDR));
    expect_val("T4_idle_valid", 0);
    tick();
    observe(32'(mem_valid));

    // T5: two gates at once
    expect_val("T5_mar", 0);
    expect_val("T5_bus_err", 1);
    expect_val("T5_nzp", 32'h2);
    GatePC = 1; GateALU = 1; LD_MAR = 1; LD_CC = 1; tick(); idle_ctl();
    observe(32'(MAR)); observe(32'(bus_err)); observe(32'(NZP));
    expect_val("T5_bus_err_sticky", 1);
    repeat (2) tick();
    observe(32'(bus_err));

    // T6: reset during BUSY
    expect_val("T6_busy", 1);
    mem_start = 1; mem_we = 0; tick(); mem_start = 0;
    observe(32'(mem_valid));
    expect_val("T6_valid_async", 0);
    expect_val("T6_mem_err", 0);
    expect_val("T6_bus_err", 0);
    expect_val("T6_pc", 32'(PCR));
    #2 Reset = 1;
    #1;
    observe(32'(mem_valid)); observe(32'(mem_err)); observe(32'(bus_err)); observe(32'(PC));
    @(negedge Clk);
    Reset = 0;
    expect_val("T6_late_mdr", 0);
    expect_val("T6_late_done", 0);
    expect_val("T6_late_valid", 0);
    mem_ready = 1; mem_rdata = 16'h1234;
    repeat (2) tick();
    mem_ready = 0;
    observe(32'(MDR)); observe(32'(mem_done)); observe(32'(mem_valid));
    expect_val("T6_read_after", 32'h4321);
    load_mdr(16'h4321);
    observe(32'(MDR));

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
